// File: rtl/frv_shfl_seq.sv
`default_nettype none
// ============================================================================
// Module   : frv_shfl_seq
// Brief    : Iterative shfl/unshfl butterfly sequencer, one stage per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module frv_shfl_seq #(
    parameter int SKIP_ZERO_STAGES = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_unshfl,
    input  logic [31:0] req_rs1,
    input  logic [3:0]  req_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_data;
    logic [3:0]  r_ctrl;
    logic        r_unshfl;
    logic [1:0]  r_ptr;
    logic [2:0]  r_cnt;

    logic [31:0] w_stage_out;
    logic [3:0]  w_mask_rest;
    logic [1:0]  w_next_ptr;
    logic [1:0]  w_first_ptr;
    logic [2:0]  w_req_n;
    logic        w_accept;

    // First enabled stage in walk order: highest bit for shfl, lowest for unshfl.
    function automatic logic [1:0] f_first(input logic [3:0] m, input logic un);
        logic [1:0] r;
        r = 2'd0;
        if (un) begin
            for (int k = 3; k >= 0; k--) if (m[k]) r = 2'(k);
        end else begin
            for (int k = 0; k < 4; k++) if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    function automatic logic [31:0] f_stage(input logic [31:0] x, input logic [1:0] k);
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  n;
        case (k)
            2'd3:    begin l = 32'h00ff0000; r = 32'h0000ff00; n = 5'd8; end
            2'd2:    begin l = 32'h0f000f00; r = 32'h00f000f0; n = 5'd4; end
            2'd1:    begin l = 32'h30303030; r = 32'h0c0c0c0c; n = 5'd2; end
            default: begin l = 32'h44444444; r = 32'h22222222; n = 5'd1; end
        endcase
        return (x & ~(l | r)) | ((x << n) & l) | ((x >> n) & r);
    endfunction

    always_comb begin
        w_stage_out = f_stage(r_data, r_ptr);
        // Stages still ahead of the pointer in the current walk direction.
        w_mask_rest = r_unshfl ? ~((4'b0010 << r_ptr) - 4'd1)
                               :  ((4'b0001 << r_ptr) - 4'd1);
        if (SKIP_ZERO_STAGES != 0) begin
            w_next_ptr  = f_first(r_ctrl & w_mask_rest, r_unshfl);
            w_first_ptr = f_first(req_ctrl, req_unshfl);
            w_req_n     = {2'b00, req_ctrl[0]} + {2'b00, req_ctrl[1]}
                        + {2'b00, req_ctrl[2]} + {2'b00, req_ctrl[3]};
        end else begin
            w_next_ptr  = r_unshfl ? r_ptr + 2'd1 : r_ptr - 2'd1;
            w_first_ptr = req_unshfl ? 2'd0 : 2'd3;
            w_req_n     = (req_ctrl != 4'd0) ? 3'd4 : 3'd0;
        end
    end

    assign req_ready  = (r_state == c_st_idle) && !flush;
    assign w_accept   = req_ready && req_valid;
    assign rsp_valid  = (r_state == c_st_done);
    assign rsp_result = r_data;
    assign busy       = (r_state != c_st_idle);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state  <= c_st_idle;
            r_data   <= 32'd0;
            r_ctrl   <= 4'd0;
            r_unshfl <= 1'b0;
            r_ptr    <= 2'd0;
            r_cnt    <= 3'd0;
        end else if (flush) begin
            r_state <= c_st_idle;
            r_ctrl  <= 4'd0;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_data   <= req_rs1;
                        r_ctrl   <= req_ctrl;
                        r_unshfl <= req_unshfl;
                        r_ptr    <= w_first_ptr;
                        r_cnt    <= w_req_n;
                        r_state  <= (w_req_n == 3'd0) ? c_st_done : c_st_run;
                    end
                end
                c_st_run: begin
                    if (r_ctrl[r_ptr]) r_data <= w_stage_out;
                    r_ptr <= w_next_ptr;
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) r_state <= c_st_done;
                end
                c_st_done: begin
                    if (rsp_ready) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frv_shfl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_shfl_seq
// Brief    : Bench for frv_shfl_seq, both stage-skip modes, against a cascade model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frv_shfl_seq;

    logic        clk;
    logic        rst        [2];
    logic        flush      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_unshfl [2];
    logic [31:0] req_rs1    [2];
    logic [3:0]  req_ctrl   [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_result [2];
    logic        busy       [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 skips disabled stages, instance 1 walks all four slots.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        frv_shfl_seq #(.SKIP_ZERO_STAGES(g == 0 ? 1 : 0)) u_dut (
            .g_clk(clk), .g_reset(rst[g]), .flush(flush[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_unshfl(req_unshfl[g]), .req_rs1(req_rs1[g]), .req_ctrl(req_ctrl[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_result(rsp_result[g]), .busy(busy[g])
        );
    end

    function automatic logic [31:0] cascade(input logic [31:0] x0, input logic [3:0] c, input bit un);
        logic [31:0] lm [4];
        logic [31:0] rm [4];
        int          sh [4];
        logic [31:0] x;
        int          k;
        lm[3] = 32'h00ff0000; rm[3] = 32'h0000ff00; sh[3] = 8;
        lm[2] = 32'h0f000f00; rm[2] = 32'h00f000f0; sh[2] = 4;
        lm[1] = 32'h30303030; rm[1] = 32'h0c0c0c0c; sh[1] = 2;
        lm[0] = 32'h44444444; rm[0] = 32'h22222222; sh[0] = 1;
        x = x0;
        for (int s = 0; s < 4; s++) begin
            k = un ? s : 3 - s;
            if (c[k]) x = (x & ~(lm[k] | rm[k])) | ((x << sh[k]) & lm[k]) | ((x >> sh[k]) & rm[k]);
        end
        return x;
    endfunction

    function automatic int slots(input int i, input logic [3:0] c);
        if (i == 0) return $countones(c);
        return (c != 4'd0) ? 4 : 0;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", name, i, got, exp);
        end
    endtask

    // Reference timeline: 0 idle, 1 working (cycles left), 2 holding a result.
    int          m_st    [2] = '{0, 0};
    int          m_left  [2] = '{0, 0};
    logic [31:0] m_res   [2];
    bit          m_zero  [2] = '{1'b0, 1'b0};
    bit          m_init  [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_st[i] <= 0; m_zero[i] <= 1'b1; m_init[i] <= 1'b1;
            end else if (flush[i]) begin
                m_st[i] <= 0;
            end else if (m_st[i] == 0) begin
                if (req_valid[i]) begin
                    m_res[i]  <= cascade(req_rs1[i], req_ctrl[i], req_unshfl[i]);
                    m_zero[i] <= 1'b0;
                    m_left[i] <= slots(i, req_ctrl[i]);
                    m_st[i]   <= (slots(i, req_ctrl[i]) == 0) ? 2 : 1;
                end
            end else if (m_st[i] == 1) begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) m_st[i] <= 2;
            end else if (rsp_ready[i]) begin
                m_st[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_init[i]) begin
                chk("req_ready", i, 32'(req_ready[i]), 32'((m_st[i] == 0) && !flush[i]));
                chk("busy", i, 32'(busy[i]), 32'(m_st[i] != 0));
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_st[i] == 2));
                if (m_st[i] == 2) chk("rsp_result", i, rsp_result[i], m_res[i]);
                else if (m_zero[i]) chk("reset_result", i, rsp_result[i], 32'd0);
            end
        end
    end

    // Issue one op from an aligned point (just after a rising edge) and pin latency/result.
    task automatic run_op(input int i, input bit un, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] exp, input int exp_lat, input bit bp);
        int lat;
        req_valid[i] = 1'b1; req_unshfl[i] = un; req_ctrl[i] = c; req_rs1[i] = x;
        rsp_ready[i] = !bp;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[i] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", i, 32'(lat), 32'(exp_lat));
        chk("result", i, rsp_result[i], exp);
        if (bp) begin
            repeat (3) begin
                chk("bp_valid", i, 32'(rsp_valid[i]), 32'd1);
                chk("bp_result", i, rsp_result[i], exp);
                chk("bp_ready", i, 32'(req_ready[i]), 32'd0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            rsp_ready[i] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_idle_busy", i, 32'(busy[i]), 32'd0);
            chk("bp_idle_ready", i, 32'(req_ready[i]), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; flush[i] = 1'b0; req_valid[i] = 1'b0; req_unshfl[i] = 1'b0;
            req_rs1[i] = 32'd0; req_ctrl[i] = 4'd0; rsp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("post_reset_result", 0, rsp_result[0], 32'd0);
        @(posedge clk); #1;

        run_op(0, 1'b0, 4'hF, 32'h0000FFFF, 32'h55555555, 5, 1'b0);
        run_op(0, 1'b1, 4'hF, 32'h55555555, 32'h0000FFFF, 5, 1'b0);
        run_op(0, 1'b0, 4'h8, 32'h12345678, 32'h12563478, 2, 1'b0);
        run_op(0, 1'b0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b0);
        run_op(1, 1'b0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b0);
        run_op(1, 1'b0, 4'h8, 32'h12345678, 32'h12563478, 5, 1'b0);
        run_op(1, 1'b1, 4'hF, 32'h55555555, 32'h0000FFFF, 5, 1'b0);
        run_op(0, 1'b1, 4'h5, 32'hA5A5F00F, cascade(32'hA5A5F00F, 4'h5, 1'b1), 3, 1'b1);

        // Flush two cycles into a full-length op.
        req_valid[0] = 1'b1; req_unshfl[0] = 1'b0; req_ctrl[0] = 4'hF; req_rs1[0] = 32'h0000FFFF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("flush_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
        end
        @(posedge clk); #1;

        // Flush coincident with a request in IDLE.
        flush[0] = 1'b1; req_valid[0] = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 0, 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        flush[0] = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        chk("flush_req_busy", 0, 32'(busy[0]), 32'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i]  = ($urandom_range(0, 2) != 0);
                req_unshfl[i] = 1'($urandom_range(0, 1));
                req_ctrl[i]   = 4'($urandom_range(0, 15));
                req_rs1[i]    = $urandom;
                rsp_ready[i]  = ($urandom_range(0, 3) != 0);
                flush[i]      = ($urandom_range(0, 49) == 0);
                rst[i]        = ($urandom_range(0, 299) == 0);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; flush[i] = 1'b0; rst[i] = 1'b0; rsp_ready[i] = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
